// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one request in flight to
// instruction memory, and presents each returned word with its PC to decode.
module ifetch_seq #(
  parameter int               WIDTH      = 64,
  parameter int               INSN_WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [WIDTH-1:0]      redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [WIDTH-1:0]      imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSN_WIDTH-1:0] imem_rsp_data,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [INSN_WIDTH-1:0] insn_data,
  output logic [WIDTH-1:0]      insn_pc
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t                state_p0, state_nxt;
  logic                  discard_p0, discard_nxt;
  logic [WIDTH-1:0]      fetch_pc_p0;
  logic [WIDTH-1:0]      req_pc_p0;
  logic                  vld_p1;
  logic [INSN_WIDTH-1:0] data_p1;
  logic [WIDTH-1:0]      pc_p1;
  logic                  out_free;
  logic                  req_fire;
  logic                  rsp_take;

  function automatic logic [WIDTH-1:0] align_pc(input logic [WIDTH-1:0] pc);
    return pc & ~WIDTH'(3);
  endfunction

  function automatic logic [WIDTH-1:0] next_pc(input logic [WIDTH-1:0] pc);
    return pc + WIDTH'(4);
  endfunction

  always_comb begin
    out_free       = ~vld_p1 | insn_ready;
    imem_req_valid = ~reset & (state_p0 == S_REQ) & out_free & ~redirect_valid;
    imem_req_addr  = reset ? RESET_PC : fetch_pc_p0;
    req_fire       = imem_req_valid & imem_req_ready;
    rsp_take       = (state_p0 == S_WAIT) & imem_rsp_valid;
    state_nxt      = state_p0;
    discard_nxt    = discard_p0;
    case (state_p0)
      S_REQ: begin
        if (req_fire) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A redirect with no response yet leaves one stale response to swallow.
        if (imem_rsp_valid) begin
          state_nxt   = S_REQ;
          discard_nxt = 1'b0;
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0   <= S_REQ;
      discard_p0 <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      discard_p0 <= discard_nxt;
    end
  end

  // p0: fetch address / outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= align_pc(redirect_pc);
    end else if (req_fire) begin
      fetch_pc_p0 <= next_pc(fetch_pc_p0);
    end
    if (req_fire) req_pc_p0 <= fetch_pc_p0;
  end

  // p1: single-entry output register toward decode
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      pc_p1   <= '0;
    end else if (redirect_valid) begin
      vld_p1 <= 1'b0;
    end else if (rsp_take && !discard_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= imem_rsp_data;
      pc_p1   <= req_pc_p0;
    end else if (vld_p1 && insn_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign insn_valid = vld_p1;
  assign insn_data  = data_p1;
  assign insn_pc    = pc_p1;

endmodule

// File: tb/tb_ifetch_seq.sv
// Bench for ifetch_seq: directed scenarios plus a random phase, with a PC
// scoreboard filled on each accepted request and drained by a decode monitor.
module tb_ifetch_seq;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        insn_ready = 1'b1;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        insn_valid;
  logic [31:0] insn_data;
  logic [63:0] insn_pc;

  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_insn_valid;
  logic [31:0] w_insn_data;
  logic [63:0] w_insn_pc;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_deliv = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] exp_pc = '0;
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          w_pend = 1'b0;
  logic [63:0] w_addr = '0;
  int          w_idx = 0;
  logic [63:0] w_exp [4] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC,
                             64'h0, 64'h4};

  always #5 clk = ~clk;

  ifetch_seq #(.WIDTH(64), .INSN_WIDTH(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn_data(insn_data), .insn_pc(insn_pc)
  );

  ifetch_seq #(.WIDTH(64), .INSN_WIDTH(32), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .insn_valid(w_insn_valid), .insn_ready(1'b1),
    .insn_data(w_insn_data), .insn_pc(w_insn_pc)
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] | 32'hA000_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: decisions taken mid-cycle describe the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      check("req_valid_in_reset", imem_req_valid, 64'd0);
      check("req_addr_in_reset", imem_req_addr, 64'h0);
      check("wrap_addr_in_reset", w_req_addr, WRAP_PC);
      sb_q.delete();
      exp_pc   = 64'h0;
      mem_pend = 1'b0;
      w_pend   = 1'b0;
    end else begin
      if (insn_valid && insn_ready && !redirect_valid) begin
        n_deliv++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_insn: got pc %h, required no instruction", insn_pc);
        end else begin
          mon_e = sb_q.pop_front();
          check("insn_pc", insn_pc, mon_e.pc);
          check("insn_data", {32'h0, insn_data}, {32'h0, mon_e.data});
        end
      end
      if (redirect_valid) check("no_req_on_redirect", imem_req_valid, 64'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_pc);
        check("single_outstanding", mem_pend, 64'd0);
        sb_q.push_back('{pc: exp_pc, data: word_of(exp_pc)});
        exp_pc   = exp_pc + 64'd4;
        mem_pend = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = int'($urandom_range(lat_max, lat_min));
      end
      if (redirect_valid) begin
        sb_q.delete();
        exp_pc = redirect_pc & ~64'h3;
      end
      if (w_req_valid) begin
        if (w_idx < 4) begin
          check("wrap_req_addr", w_req_addr, w_exp[w_idx]);
          w_idx++;
        end
        w_pend = 1'b1;
        w_addr = w_req_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(mem_addr);
        mem_pend       = 1'b0;
      end
    end
    w_rsp_valid = w_pend;
    w_rsp_data  = w_addr[31:0];
    w_pend      = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_valid", insn_valid, 64'd0);
    check("post_reset_pc", insn_pc, 64'h0);
    check("post_reset_data", {32'h0, insn_data}, 64'h0);
  endtask

  task automatic wait_insn(input string name, input logic [63:0] pc);
    int k;
    k = 0;
    while (k < 60) begin
      step();
      if (insn_valid) break;
      k++;
    end
    check(name, insn_valid ? insn_pc : 64'hDEAD_DEAD_DEAD_DEAD, pc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit did_reset;

    // Streaming, 1-cycle memory: one instruction every two cycles
    n_deliv = 0;
    do_reset();
    repeat (10) step();
    check("t1_throughput", n_deliv, 64'd4);

    // Decode backpressure holds the output register and blocks requests
    insn_ready = 1'b0;
    do_reset();
    k = 0;
    while (!insn_valid && k < 20) begin step(); k++; end
    check("t2_first_valid", insn_valid, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", insn_valid, 64'd1);
      check("t2_hold_pc", insn_pc, 64'h0);
      check("t2_hold_data", {32'h0, insn_data}, 64'hA000_0000);
      check("t2_no_req", imem_req_valid, 64'd0);
      step();
    end
    insn_ready = 1'b1;
    @(negedge clk);
    check("t2_release_req", imem_req_valid, 64'd1);
    check("t2_release_addr", imem_req_addr, 64'h4);

    // Redirect while waiting on a 3-cycle memory
    lat_min = 3;
    lat_max = 3;
    do_reset();
    k = 0;
    while (!(imem_req_valid && imem_req_addr == 64'h8) && k < 60) begin step(); k++; end
    check("t3_reach_req8", k < 60, 64'd1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_discard_wait", imem_req_valid, 64'd0);
    wait_insn("t3_redirect_pc", 64'h1000);
    k = 0;
    while (!imem_req_valid && k < 20) begin step(); k++; end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    step();
    redirect_pc    = 64'h3000;
    step();
    redirect_valid = 1'b0;
    wait_insn("t3_b2b_pc", 64'h3000);

    // Redirect against a full output register, then against a live response
    lat_min = 1;
    lat_max = 1;
    do_reset();
    k = 0;
    while (!(insn_valid && insn_pc == 64'h4) && k < 30) begin step(); k++; end
    check("t4_reach_pc4", k < 30, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_flushed_valid", insn_valid, 64'd0);
    wait_insn("t4_flush_pc", 64'h2000);
    k = 0;
    while (!imem_rsp_valid && k < 20) begin step(); k++; end
    check("t4_reach_rsp", imem_rsp_valid, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3006;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4b_dropped", insn_valid, 64'd0);
    check("t4b_req_valid", imem_req_valid, 64'd1);
    check("t4b_req_addr", imem_req_addr, 64'h3004);
    wait_insn("t4b_pc", 64'h3004);

    // Wrap-around instance collected its first four request addresses
    check("t5_wrap_count", w_idx, 64'd4);

    // Random traffic with one reset landing mid-request
    lat_min   = 1;
    lat_max   = 3;
    n_deliv   = 0;
    did_reset = 1'b0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if (!did_reset && i >= 500 && mem_pend) begin
        do_reset();
        did_reset = 1'b1;
      end
      imem_req_ready = ($urandom_range(3, 0) != 0);
      insn_ready     = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = {$urandom, $urandom};
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    insn_ready     = 1'b1;
    repeat (20) step();
    check("t6_reset_mid_wait", did_reset, 64'd1);
    check("t6_progress", n_deliv > 50, 64'd1);
    check("t6_drained", sb_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
